// File: rtl/debug_bus_pkg.sv
// rtl/debug_bus_pkg.sv - shared types and constants for the debug bus master
//
// Purpose: FSM state encoding, response status codes, bus widths and the
//          response frame length used by debug_bus_master and
//          debug_bus_frame_tx.
// Ports:   none (package).
// Config:  DEBUG_BUS_MASTER_CHECKSUM_EN - response frame carries a trailing
//          XOR checksum byte (10 bytes instead of 9).

package debug_bus_pkg;

   localparam int DBG_BUS_DATA_W = 64;
   localparam int DBG_BUS_ADDR_W = 8;

   // Bus address of the RAM debug port responder.
   localparam logic [DBG_BUS_ADDR_W-1:0] DBG_ADDR_RAM = 8'd2;

   // Response status byte.
   localparam logic [7:0] DBG_ST_OK       = 8'h00;
   localparam logic [7:0] DBG_ST_ACC_TO   = 8'h01;
   localparam logic [7:0] DBG_ST_AVAIL_TO = 8'h02;

`ifdef DEBUG_BUS_MASTER_CHECKSUM_EN
   localparam int DBG_RSP_BYTES = 10;
`else
   localparam int DBG_RSP_BYTES = 9;
`endif

   typedef enum logic [2:0] {
      ST_RX_ADDR    = 3'd0,
      ST_RX_DATA    = 3'd1,
      ST_START      = 3'd2,
      ST_WAIT_ACC   = 3'd3,
      ST_WAIT_AVAIL = 3'd4,
      ST_TX         = 3'd5
   } dbg_state_e;

endpackage

// File: rtl/debug_bus_frame_tx.sv
// rtl/debug_bus_frame_tx.sv - response frame serializer for the debug bus master
//
// Purpose: loads status + 64-bit result in one cycle and streams them out
//          LSB-first as a valid/ready byte stream; pulses done_o on the
//          handshake of the final byte.
// Ports:   clk, rst        clock, synchronous active-high reset
//          load_i          start a new frame (only while idle)
//          status_i[7:0]   status byte, sent first
//          result_i[63:0]  result word, sent least-significant byte first
//          rsp_data_o/rsp_valid_o/rsp_ready_i  byte stream to the host link
//          done_o          final byte accepted this cycle
// Config:  DEBUG_BUS_MASTER_CHECKSUM_EN - append XOR of the 9 preceding bytes.

module debug_bus_frame_tx
   import debug_bus_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_i,
   input  logic [7:0]                status_i,
   input  logic [DBG_BUS_DATA_W-1:0] result_i,
   output logic [7:0]                rsp_data_o,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic                      done_o
);

   localparam int         SH_W = DBG_BUS_DATA_W + 8;
   localparam logic [3:0] LAST = 4'(DBG_RSP_BYTES - 1);

   logic [SH_W-1:0] sh_q, sh_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            valid_q, valid_d;
   logic [7:0]      cur_byte;
   logic            hs;

`ifdef DEBUG_BUS_MASTER_CHECKSUM_EN
   logic [7:0] csum_q, csum_d;

   // Once the 9 data bytes have shifted out, the checksum takes the output.
   assign cur_byte = (cnt_q == 4'd9) ? csum_q : sh_q[7:0];
`else
   assign cur_byte = sh_q[7:0];
`endif

   assign hs          = valid_q & rsp_ready_i;
   assign rsp_data_o  = cur_byte;
   assign rsp_valid_o = valid_q;

   always_comb begin
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      done_o  = 1'b0;
`ifdef DEBUG_BUS_MASTER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
      if (load_i) begin
         sh_d    = {result_i, status_i};
         cnt_d   = 4'd0;
         valid_d = 1'b1;
`ifdef DEBUG_BUS_MASTER_CHECKSUM_EN
         csum_d  = 8'h00;
`endif
      end else if (hs) begin
         sh_d = {8'h00, sh_q[SH_W-1:8]};
`ifdef DEBUG_BUS_MASTER_CHECKSUM_EN
         csum_d = csum_q ^ cur_byte;
`endif
         if (cnt_q == LAST) begin
            valid_d = 1'b0;
            done_o  = 1'b1;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q    <= '0;
         cnt_q   <= 4'd0;
         valid_q <= 1'b0;
`ifdef DEBUG_BUS_MASTER_CHECKSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
`ifdef DEBUG_BUS_MASTER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

endmodule

// File: rtl/debug_bus_master.sv
// rtl/debug_bus_master.sv - host-link to 64-bit debug bus initiator
//
// Purpose: receives a 9-byte command (addr, data LSB-first) from the host
//          link, runs one debug bus transaction and returns a status +
//          8-byte result frame to the host link.
// Ports:   clk, rst                       clock, synchronous active-high reset
//          cmd_data/cmd_valid/cmd_ready   command byte stream from host
//          rsp_data/rsp_valid/rsp_ready   response byte stream to host
//          bus_addr[7:0]                  responder select, held until next cmd
//          bus_start                      one-cycle transaction start
//          bus_data[63:0]                 inout, driven only during START
//          bus_accepted, bus_available    responder handshakes (only 1 counts)
//          busy                           not idle in RX_ADDR
// Params:  TIMEOUT_CYCLES                 cycles per wait state before abort
// Config:  DEBUG_BUS_MASTER_CHECKSUM_EN   adds a checksum byte to responses.

module debug_bus_master
   import debug_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                cmd_data,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   output logic [7:0]                rsp_data,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DBG_BUS_ADDR_W-1:0] bus_addr,
   output logic                      bus_start,
   inout  wire  [DBG_BUS_DATA_W-1:0] bus_data,
   input  logic                      bus_accepted,
   input  logic                      bus_available,
   output logic                      busy
);

   localparam int          TW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

   dbg_state_e                state_q, state_d;
   logic [DBG_BUS_ADDR_W-1:0] addr_q, addr_d;
   logic [DBG_BUS_DATA_W-1:0] cmd_q, cmd_d;
   logic [3:0]                bcnt_q, bcnt_d;
   logic [TW-1:0]             tcnt_q, tcnt_d;

   logic                      acc, avail;
   logic                      tx_load, tx_done;
   logic [7:0]                tx_status;
   logic [DBG_BUS_DATA_W-1:0] tx_result;

   // Unaddressed responders float the handshakes; only a clean 1 is a hit.
   assign acc   = (bus_accepted === 1'b1);
   assign avail = (bus_available === 1'b1);

   assign bus_data  = (state_q == ST_START) ? cmd_q : {DBG_BUS_DATA_W{1'bz}};
   assign bus_start = (state_q == ST_START);
   assign bus_addr  = addr_q;
   assign cmd_ready = (state_q == ST_RX_ADDR) || (state_q == ST_RX_DATA);
   assign busy      = (state_q != ST_RX_ADDR);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      cmd_d     = cmd_q;
      bcnt_d    = bcnt_q;
      tcnt_d    = tcnt_q;
      tx_load   = 1'b0;
      tx_status = DBG_ST_OK;
      tx_result = '0;
      case (state_q)
         ST_RX_ADDR: begin
            if (cmd_valid) begin
               addr_d  = cmd_data;
               bcnt_d  = 4'd0;
               state_d = ST_RX_DATA;
            end
         end
         ST_RX_DATA: begin
            if (cmd_valid) begin
               // Shift in from the top so byte 0 ends up in bits [7:0].
               cmd_d  = {cmd_data, cmd_q[DBG_BUS_DATA_W-1:8]};
               bcnt_d = bcnt_q + 4'd1;
               if (bcnt_d == 4'd8) begin
                  state_d = ST_START;
               end
            end
         end
         ST_START: begin
            tcnt_d  = '0;
            state_d = ST_WAIT_ACC;
         end
         ST_WAIT_ACC: begin
            if (acc && avail) begin
               tx_load   = 1'b1;
               tx_result = bus_data;
               state_d   = ST_TX;
            end else if (acc) begin
               tcnt_d  = '0;
               state_d = ST_WAIT_AVAIL;
            end else if (tcnt_q == TLIM) begin
               tx_load   = 1'b1;
               tx_status = DBG_ST_ACC_TO;
               state_d   = ST_TX;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         ST_WAIT_AVAIL: begin
            if (avail) begin
               tx_load   = 1'b1;
               tx_result = bus_data;
               state_d   = ST_TX;
            end else if (tcnt_q == TLIM) begin
               tx_load   = 1'b1;
               tx_status = DBG_ST_AVAIL_TO;
               state_d   = ST_TX;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         ST_TX: begin
            if (tx_done) begin
               state_d = ST_RX_ADDR;
            end
         end
         default: begin
            state_d = ST_RX_ADDR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RX_ADDR;
         addr_q  <= '0;
         cmd_q   <= '0;
         bcnt_q  <= 4'd0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cmd_q   <= cmd_d;
         bcnt_q  <= bcnt_d;
         tcnt_q  <= tcnt_d;
      end
   end

   debug_bus_frame_tx u_frame_tx (
      .clk         (clk),
      .rst         (rst),
      .load_i      (tx_load),
      .status_i    (tx_status),
      .result_i    (tx_result),
      .rsp_data_o  (rsp_data),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .done_o      (tx_done)
   );

endmodule

// File: doc/debug_bus_master.md
Name: debug_bus_master

Overview:
- Initiator end of the 64-bit debug bus; the debug bus responders (RAM debug port at bus address 2, etc.) sit on the other end.
- Takes a framed byte-stream command from the host link (UART RX side), runs exactly one debug bus transaction, and returns a framed byte-stream response to the host link (UART TX side).
- Sits between the host serial link and all debug bus responders; it is the only driver of bus_addr and bus_start.

Parameters:
- TIMEOUT_CYCLES, 1024, cycles allowed in each of WAIT_ACC and WAIT_AVAIL before abort (min 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd_data  in  8  command byte from host link
- cmd_valid  in  1  cmd_data valid
- cmd_ready  out  1  byte consumed when cmd_valid && cmd_ready at posedge
- rsp_data  out  8  response byte to host link
- rsp_valid  out  1  rsp_data valid
- rsp_ready  in  1  byte taken when rsp_valid && rsp_ready at posedge
- bus_addr  out  8  responder select; held for the whole transaction
- bus_start  out  1  one-cycle transaction start
- bus_data  inout  64  driven by master only in START; otherwise high-Z
- bus_accepted  in  1  responder accepted start
- bus_available  in  1  responder result valid on bus_data this cycle
- busy  out  1  high in any state other than RX_ADDR

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, bus_addr=0, bus_start=0, bus_data high-Z, busy=0, state=RX_ADDR.
- Reset mid-transaction aborts the transaction and discards any partial command or response. No response is sent.
- Only a sampled value of exactly 1 counts as asserted on bus_accepted/bus_available. Z/X counts as 0 (unaddressed responders float these).
- Command frame is 9 bytes: addr, then data bytes 0..7, least-significant byte first (byte k goes to bus_data[8k+7:8k]).
- Response frame is 9 bytes: status, then result bytes 0..7, least-significant byte first. Status codes: 0x00 OK, 0x01 accept timeout, 0x02 available timeout.
- RX_ADDR: cmd_ready=1. On handshake, latch bus_addr, clear byte counter, go to RX_DATA.
- RX_DATA: cmd_ready=1. Each handshake latches a byte into the command shift register. After the 8th byte, go to START.
- START (exactly 1 cycle): bus_start=1, bus_data driven with the command word, cmd_ready=0. Next state WAIT_ACC; timeout counter cleared.
- WAIT_ACC: bus_data released.
  - accepted=1: go to WAIT_AVAIL, counter cleared.
  - accepted and available both 1 in the same cycle: capture bus_data and status 0x00, go to TX.
  - Counter reaches TIMEOUT_CYCLES-1 with no accept: result=0, status 0x01, go to TX.
- WAIT_AVAIL:
  - available=1: capture bus_data as result, status 0x00, go to TX.
  - Timeout: result=0, status 0x02, go to TX.
- TX: rsp_valid=1, rsp_data=current byte. Advance on each rsp_ready handshake. rsp_data is stable while rsp_valid && !rsp_ready. After the last byte, go to RX_ADDR.
- cmd_ready=0 in START/WAIT_ACC/WAIT_AVAIL/TX. No command bytes are buffered during a transaction.
- bus_addr holds its value after a transaction until the next addr byte is latched.
- Latency: START occurs the cycle after the 9th command handshake. The first rsp_valid occurs the cycle after the available/timeout event.
- Counters are free of wrap-around: the timeout counter saturates at TIMEOUT_CYCLES-1. The byte counter is 4 bits, compared to 8 (or 9 with the optional feature).

Optional Feature:
- Macro DEBUG_BUS_MASTER_CHECKSUM_EN.
- Defined: the response gains a 10th byte, the XOR of the 9 preceding bytes.
- Undefined: the response is exactly 9 bytes.
- Command format is unchanged either way.

Decomposition:
- Shared package debug_bus_pkg:
  - state enum (RX_ADDR, RX_DATA, START, WAIT_ACC, WAIT_AVAIL, TX)
  - status constants DBG_ST_OK/DBG_ST_ACC_TO/DBG_ST_AVAIL_TO
  - DBG_BUS_DATA_W=64, DBG_BUS_ADDR_W=8
  - debug RAM bus address constant 8'd2
- One natural sub-module, debug_bus_frame_tx: response serializer (shift register, byte counter, optional checksum, valid/ready).

Test Plan:
- Write via RAM responder model at addr 2: cmd bytes 02, 01 23 01 00 00 00 00 AB (word 0xAB00000000012301) -> bus_start high 1 cycle with that word; model ack; response 00 7B 00 00 00 00 00 00 00.
- Read at addr 2 where model returns 0xFFFFFFFFFFFFFF5A on available -> response 00 5A FF FF FF FF FF FF FF; bus_data is Z from the cycle after START onward.
- Unmapped addr 0x77 (accepted floats Z) -> after TIMEOUT_CYCLES cycles, response 01 followed by 8 zero bytes.
- Responder accepts but never asserts available -> response 02 followed by 8 zero bytes; next command is then accepted normally.
- rsp_ready toggled 0/1 randomly during TX -> bytes unchanged while stalled, no byte lost or duplicated; cmd_ready stays 0 until the last byte is sent.
- rst asserted in WAIT_AVAIL -> next cycle bus_start=0, bus_data Z, cmd_ready=1, no response bytes; with DEBUG_BUS_MASTER_CHECKSUM_EN, the OK write case ends with checksum byte 0x7B.
